// File: rtl/reaction_scorer_if.sv
// Handshake/bus bundle between the reaction scorer and the game controller /
// display side. The scorer takes the slave view; the driver of the inputs takes master.
interface reaction_scorer_if #(
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned TIME_W  = 11
);

  logic               start;
  logic               stop;
  logic               led_in;
  logic               btn;
  logic               rng_enable;
  logic               target_led;
  logic [TIME_W-1:0]  reaction_ms;
  logic [SCORE_W-1:0] hits;
  logic [SCORE_W-1:0] misses;
  logic               result_valid;
  logic [1:0]         result_code;

  modport master (
    output start,
    output stop,
    output led_in,
    output btn,
    input  rng_enable,
    input  target_led,
    input  reaction_ms,
    input  hits,
    input  misses,
    input  result_valid,
    input  result_code
  );

  modport slave (
    input  start,
    input  stop,
    input  led_in,
    input  btn,
    output rng_enable,
    output target_led,
    output reaction_ms,
    output hits,
    output misses,
    output result_valid,
    output result_code
  );

endinterface

// File: rtl/reaction_scorer.sv
// Reaction-game round controller: arms the LED randomiser, lights the target,
// times the player's press in ms and keeps saturating hit/miss tallies.
module reaction_scorer #(
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned TIMEOUT_MS  = 1000,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned TIME_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  reaction_scorer_if.slave bus
);

  localparam int unsigned        PRE_W     = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [TIME_W-1:0]  TIMEOUT   = TIME_W'(TIMEOUT_MS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  localparam logic [1:0] CODE_HIT     = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_FALSE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_REPORT,
    S_HOLDOFF
  } state_e;

  state_e state_q, state_d;

  logic               btn_q, btn_d;
  logic               edge_q, edge_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [TIME_W-1:0]  ms_q, ms_d;
  logic [TIME_W-1:0]  reaction_q, reaction_d;
  logic [SCORE_W-1:0] hits_q, hits_d;
  logic [SCORE_W-1:0] misses_q, misses_d;
  logic [1:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               rng_q, rng_d;
  logic               led_q, led_d;

  logic [SCORE_W-1:0] hits_inc;
  logic [SCORE_W-1:0] misses_inc;

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      btn_q      <= 1'b0;
      edge_q     <= 1'b0;
      pre_q      <= '0;
      ms_q       <= '0;
      reaction_q <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      rng_q      <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      edge_q     <= edge_d;
      pre_q      <= pre_d;
      ms_q       <= ms_d;
      reaction_q <= reaction_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      rng_q      <= rng_d;
      led_q      <= led_d;
    end
  end

  // Next-state, round timing and scoring.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    ms_d       = ms_q;
    reaction_d = reaction_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    code_d     = code_q;

    // The press edge is registered so the FSM only ever acts on a clean, one-cycle pulse.
    btn_d  = bus.btn;
    edge_d = bus.btn & ~btn_q;

    hits_inc   = (hits_q == SCORE_MAX)   ? hits_q   : hits_q + SCORE_W'(1);
    misses_inc = (misses_q == SCORE_MAX) ? misses_q : misses_q + SCORE_W'(1);

    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_ARMED;
          end
        end

        S_ARMED: begin
          if (edge_q) begin
            state_d  = S_REPORT;
            code_d   = CODE_FALSE;
            misses_d = misses_inc;
          end else if (bus.led_in) begin
            state_d = S_ACTIVE;
            pre_d   = '0;
            ms_d    = '0;
          end
        end

        S_ACTIVE: begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (ms_q != TIMEOUT) begin
              ms_d = ms_q + TIME_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end

          // A press landing on the timeout millisecond still scores as a hit.
          if (edge_q) begin
            state_d    = S_REPORT;
            code_d     = CODE_HIT;
            reaction_d = ms_q;
            hits_d     = hits_inc;
          end else if (ms_q == TIMEOUT) begin
            state_d  = S_REPORT;
            code_d   = CODE_TIMEOUT;
            misses_d = misses_inc;
          end
        end

        S_REPORT: begin
          state_d = S_HOLDOFF;
        end

        S_HOLDOFF: begin
          if (!bus.btn) begin
            state_d = S_ARMED;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    valid_d = (state_d == S_REPORT);
    rng_d   = (state_d == S_ARMED);
    led_d   = (state_d == S_ACTIVE);
  end

  assign bus.rng_enable   = rng_q;
  assign bus.target_led   = led_q;
  assign bus.reaction_ms  = reaction_q;
  assign bus.hits         = hits_q;
  assign bus.misses       = misses_q;
  assign bus.result_valid = valid_q;
  assign bus.result_code  = code_q;

endmodule

// File: tb/tb_reaction_scorer.sv
// Directed, table-driven bench for reaction_scorer with small timing parameters.
module tb_reaction_scorer;

  localparam int unsigned CLKS_PER_MS = 4;
  localparam int unsigned TIMEOUT_MS  = 10;
  localparam int unsigned SCORE_W     = 3;
  localparam int unsigned TIME_W      = 11;

  localparam int K_HIT   = 0;
  localparam int K_TMO   = 1;
  localparam int K_EARLY = 2;
  localparam int K_SAME  = 3;

  typedef struct {
    int         kind;
    int         delay;
    logic [1:0] code;
    int         rms;
    int         hits;
    int         misses;
    int         lat;
  } vec_t;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;
  vec_t vecs[$];

  reaction_scorer_if #(.SCORE_W(SCORE_W), .TIME_W(TIME_W)) bus ();

  reaction_scorer #(
    .CLKS_PER_MS(CLKS_PER_MS),
    .TIMEOUT_MS (TIMEOUT_MS),
    .SCORE_W    (SCORE_W),
    .TIME_W     (TIME_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int kind, input int delay, input logic [1:0] code,
                              input int rms, input int hits, input int misses, input int lat);
    vec_t v;
    v.kind = kind; v.delay = delay; v.code = code; v.rms = rms;
    v.hits = hits; v.misses = misses; v.lat = lat;
    return v;
  endfunction

  // One round from ARMED; lat counts clocks from the first driven stimulus to result_valid.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit done;
    bit saw_tgt;
    string tag;
    lat = 0; done = 0; saw_tgt = 0;
    tag = $sformatf("v%0d", idx);
    check({tag, "_armed"}, 32'(bus.rng_enable), 1);
    if (v.kind == K_HIT || v.kind == K_TMO) bus.led_in = 1'b1;
    else bus.btn = 1'b1;
    while (!done && lat < 100) begin
      tick();
      lat++;
      bus.led_in = (v.kind == K_SAME && lat == 1);
      if (v.kind == K_HIT && lat == v.delay + 1) bus.btn = 1'b1;
      if (bus.target_led) saw_tgt = 1;
      if (bus.result_valid) done = 1;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_code"}, 32'(bus.result_code), 32'(v.code));
    check({tag, "_reaction_ms"}, 32'(bus.reaction_ms), 32'(v.rms));
    check({tag, "_hits"}, 32'(bus.hits), 32'(v.hits));
    check({tag, "_misses"}, 32'(bus.misses), 32'(v.misses));
    check({tag, "_target_off"}, 32'(bus.target_led), 0);
    check({tag, "_target_seen"}, 32'(saw_tgt), 32'(v.kind == K_HIT || v.kind == K_TMO));
    bus.btn = 1'b0;
    tick();
    check({tag, "_valid_pulse"}, 32'(bus.result_valid), 0);
    tick();
    check({tag, "_rearm"}, 32'(bus.rng_enable), 1);
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.led_in = 1'b0; bus.btn = 1'b0;

    vecs.push_back(mk(K_HIT,   13, 2'b01,  3, 1, 0, 16));
    vecs.push_back(mk(K_TMO,    0, 2'b10,  3, 1, 1, 42));
    vecs.push_back(mk(K_EARLY,  0, 2'b11,  3, 1, 2,  2));
    vecs.push_back(mk(K_SAME,   0, 2'b11,  3, 1, 3,  2));
    vecs.push_back(mk(K_HIT,   39, 2'b01, 10, 2, 3, 42));
    vecs.push_back(mk(K_HIT,    0, 2'b01,  0, 3, 3,  3));
    vecs.push_back(mk(K_HIT,    3, 2'b01,  1, 4, 3,  6));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(K_HIT, 5, 2'b01, 1, (5 + i > 7) ? 7 : 5 + i, 3, 8));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(K_EARLY, 0, 2'b11, 1, 7, (4 + i > 7) ? 7 : 4 + i, 2));

    tick(); tick();
    check("rst_rng_enable", 32'(bus.rng_enable), 0);
    check("rst_target_led", 32'(bus.target_led), 0);
    check("rst_reaction_ms", 32'(bus.reaction_ms), 0);
    check("rst_hits", 32'(bus.hits), 0);
    check("rst_misses", 32'(bus.misses), 0);
    check("rst_valid", 32'(bus.result_valid), 0);
    check("rst_code", 32'(bus.result_code), 0);
    reset = 1'b0;
    tick();
    check("idle_no_arm", 32'(bus.rng_enable), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Button held through REPORT keeps the FSM parked in HOLDOFF.
    bus.led_in = 1'b1;
    tick();
    bus.led_in = 1'b0;
    tick();
    bus.btn = 1'b1;
    for (int i = 0; i < 10 && !bus.result_valid; i++) tick();
    check("hold_valid", 32'(bus.result_valid), 1);
    check("hold_code", 32'(bus.result_code), 32'(2'b01));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_no_arm", 32'({bus.rng_enable, bus.result_valid}), 0);
    end
    bus.btn = 1'b0;
    tick();
    check("hold_release_arm", 32'(bus.rng_enable), 1);

    // stop in ACTIVE returns to IDLE, keeps tallies, emits no result.
    bus.led_in = 1'b1;
    tick();
    bus.led_in = 1'b0;
    tick(); tick(); tick();
    check("stop_pre_target", 32'(bus.target_led), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_target", 32'(bus.target_led), 0);
    check("stop_idle", 32'(bus.rng_enable), 0);
    check("stop_valid", 32'(bus.result_valid), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stop_idle_quiet", 32'({bus.result_valid, bus.rng_enable, bus.target_led}), 0);
    end
    check("stop_hits_kept", 32'(bus.hits), 7);
    check("stop_misses_kept", 32'(bus.misses), 7);
    check("stop_code_kept", 32'(bus.result_code), 32'(2'b01));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_arm", 32'(bus.rng_enable), 1);

    // Asynchronous reset in the middle of ACTIVE.
    bus.led_in = 1'b1;
    tick();
    bus.led_in = 1'b0;
    tick(); tick();
    check("mid_target", 32'(bus.target_led), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_target", 32'(bus.target_led), 0);
    check("async_hits", 32'(bus.hits), 0);
    check("async_misses", 32'(bus.misses), 0);
    check("async_code", 32'(bus.result_code), 0);
    check("async_reaction", 32'(bus.reaction_ms), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_quiet", 32'({bus.result_valid, bus.rng_enable, bus.target_led}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
